// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state type and constants for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic {RUN, WAIT} hz_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [4:0]  REG_ZERO  = 5'd0;
endpackage

// File: rtl/pipeline_hazard_controller_hz_sat_counter.sv
// hz_sat_counter: W-bit event counter that sticks at all-ones instead of wrapping
//  clk, reset (async, active-high), inc (count this cycle), count (current value)
module hz_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/freeze control for a 5-stage pipeline
//  inputs : ID source regs/uses, EX load + rd, MEM redirect, data-memory req/ready
//  outputs: pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze,
//           pc_redirect (combinational); mem_timeout, stall_count, flush_count (registered)
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_freeze,
  output logic             pc_redirect,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  hz_state_t state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic load_use, mem_stall, lu_only;
  always_comb begin
    load_use = ex_mem_read && ex_rd != REG_ZERO &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    mem_stall = dmem_req && !dmem_ready;
    pipe_freeze = !reset && mem_stall;
    pc_redirect = !reset && !mem_stall && mem_redirect;
    lu_only = !reset && !mem_stall && !mem_redirect && load_use;
    pc_stall = pipe_freeze || lu_only;
    if_id_stall = pipe_freeze || lu_only;
    if_id_flush = pc_redirect;
    id_ex_flush = pc_redirect || lu_only;
    ex_mem_flush = pc_redirect;
  end
  // An aborted access (dmem_req dropped) leaves WAIT just like a completed one.
  always_comb begin
    state_nx = state;
    state_nx = (state == RUN) ? (mem_stall ? WAIT : RUN)
                              : ((!dmem_req || dmem_ready) ? RUN : WAIT);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RUN;
    else state <= state_nx;
  // wait_cnt holds the number of stalled cycles already completed; it saturates
  // at MEM_TIMEOUT-1 since the sticky flag makes further counting pointless.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wait_cnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wait_cnt <= (state_nx == WAIT)
                  ? ((wait_cnt == WW'(MEM_TIMEOUT - 1)) ? wait_cnt : wait_cnt + 1'b1)
                  : '0;
      if (mem_stall && wait_cnt == WW'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
    end
  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (pc_stall),
    .count(stall_count)
  );
  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (pc_redirect),
    .count(flush_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed scoreboard bench for the hazard controller
module tb_pipeline_hazard_controller;
  import hazard_pkg::*;
  localparam int MT   = 4;
  localparam int CW   = 3;
  localparam int CMAX = 7;
  logic clk = 0, reset = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, mem_redirect = 0;
  logic dmem_req = 0, dmem_ready = 0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze, pc_redirect;
  logic mem_timeout;
  logic [CW-1:0] stall_count, flush_count;
  int checks = 0, errors = 0;
  int m_stall = 0, m_flush = 0, m_wait = 0;
  logic m_to = 0;
  logic [6:0] sb[$];

  pipeline_hazard_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_redirect(mem_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .pipe_freeze(pipe_freeze),
    .pc_redirect(pc_redirect), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctrl_now();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze, pc_redirect};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive inputs, predict controls, compare, clock, compare registered state.
  task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                      input logic mr, input logic [4:0] rd, input logic redir,
                      input logic req, input logic rdy);
    logic ms, lu;
    logic [6:0] e;
    @(negedge clk);
    id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_mem_read = mr; ex_rd = rd; mem_redirect = redir; dmem_req = req; dmem_ready = rdy;
    ms = req && !rdy;
    lu = mr && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
    // order: pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze, pc_redirect
    sb.push_back(ms ? 7'b1100010 : redir ? 7'b0011101 : lu ? 7'b1101000 : 7'b0000000);
    #1;
    e = sb.pop_front();
    chk("ctrl", 32'(ctrl_now()), 32'(e));
    if (e[6] && m_stall < CMAX) m_stall++;
    if (e[0] && m_flush < CMAX) m_flush++;
    if (ms && m_wait == MT - 1) m_to = 1;
    m_wait = ms ? ((m_wait == MT - 1) ? m_wait : m_wait + 1) : 0;
    @(posedge clk);
    #1;
    chk("stall_count", 32'(stall_count), 32'(m_stall));
    chk("flush_count", 32'(flush_count), 32'(m_flush));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; mem_redirect = 0; dmem_req = 0; dmem_ready = 0;
    #1;
    chk("rst_ctrl", 32'(ctrl_now()), 0);
    chk("rst_cnts", {stall_count, flush_count, mem_timeout}, 0);
    chk("rst_state", 32'(dut.state), 32'(RUN));
    m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    do_reset();
    // lw x5 in EX, add x6,x5,x1 in ID: one stall, then the bubble clears it
    step(5, 1, 1, 1, 1, 5, 0, 0, 0);
    chk("t1_stall_cnt", 32'(stall_count), 1);
    step(6, 5, 1, 1, 0, 0, 0, 0, 0);
    // rd==0 never stalls; unused rs2 matching rd does not stall
    step(0, 0, 1, 1, 1, 0, 0, 0, 0);
    step(3, 7, 1, 0, 1, 7, 0, 0, 0);
    chk("t2_stall_cnt", 32'(stall_count), 1);
    // redirect together with a load-use hazard: redirect wins
    step(5, 1, 1, 1, 1, 5, 1, 0, 0);
    chk("t3_pc_stall", 32'(pc_stall), 0);
    chk("t3_flush_cnt", 32'(flush_count), 1);
    do_reset();
    // three wait cycles then ready
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t4_state_wait", 32'(dut.state), 32'(WAIT));
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("t4_state_run", 32'(dut.state), 32'(RUN));
    chk("t4_stall_cnt", 32'(stall_count), 3);
    // redirect during a memory wait: freeze first, redirect on the ready cycle
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1);
    chk("t4_flush_cnt", 32'(flush_count), 1);
    chk("t4_stall_cnt2", 32'(stall_count), 4);
    do_reset();
    // watchdog: ready held low for 10 cycles
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      if (i == 3) chk("t5_to_before", 32'(mem_timeout), 0);
      if (i == 4) chk("t5_to_after", 32'(mem_timeout), 1);
    end
    chk("t5_freeze_held", 32'(pipe_freeze), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("t5_to_sticky", 32'(mem_timeout), 1);
    chk("t5_stall_sat", 32'(stall_count), 7);
    do_reset();
    // nine load-use stalls saturate a 3-bit counter at 7
    for (int i = 0; i < 9; i++) step(9, 2, 0, 1, 1, 2, 0, 0, 0);
    chk("t6_stall_sat", 32'(stall_count), 7);
    // asynchronous reset in the middle of a wait
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t6_in_wait", 32'(dut.state), 32'(WAIT));
    #2 reset = 1;
    #1;
    chk("t6_async_ctrl", 32'(ctrl_now()), 0);
    chk("t6_async_cnts", {stall_count, flush_count, mem_timeout}, 0);
    chk("t6_async_state", 32'(dut.state), 32'(RUN));
    @(negedge clk);
    reset = 0; dmem_req = 0;
    m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
